// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (restoring shift-subtract).
// Optional DIV_EARLY_OUT_EN skips iteration when |a| < |b|.
module alu_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [1:0]       div_op_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             ex_ready_i,
    input  logic             kill_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             busy_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, quo_r, mag_b_r;
    logic             is_rem_r, neg_q_r, neg_r_r;

    logic             a_neg, b_neg, b_zero, ovf, special, early, accept;
    logic [WIDTH-1:0] mag_a, mag_b, special_res, fix_res;
    logic [WIDTH:0]   shifted, trial;

    assign a_neg   = div_op_i[0] & operand_a_i[WIDTH-1];
    assign b_neg   = div_op_i[0] & operand_b_i[WIDTH-1];
    assign mag_a   = a_neg ? -operand_a_i : operand_a_i;
    assign mag_b   = b_neg ? -operand_b_i : operand_b_i;
    assign b_zero  = operand_b_i == '0;
    assign ovf     = div_op_i[0] && operand_a_i == {1'b1, {(WIDTH-1){1'b0}}} && &operand_b_i;
    assign special = b_zero || ovf;
    assign accept  = state == IDLE && enable_i && !kill_i;
`ifdef DIV_EARLY_OUT_EN
    assign early   = !b_zero && mag_a < mag_b;
`else
    assign early   = 1'b0;
`endif
    // Overflow quotient equals the dividend itself (2^(WIDTH-1)).
    assign special_res = b_zero ? (div_op_i[1] ? operand_a_i : '1)
                                : (div_op_i[1] ? '0 : operand_a_i);

    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign trial   = shifted - {1'b0, mag_b_r};
    assign fix_res = is_rem_r ? (neg_r_r ? -rem_r : rem_r)
                              : (neg_q_r ? -quo_r : quo_r);

    assign ready_o = state == DONE;
    assign busy_o  = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : (early ? FIXUP : ITER);
            ITER:    if (cnt == '0) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    if (ex_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill_i) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            mag_b_r  <= '0;
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_o <= '0;
        end else if (accept) begin
            cnt      <= CW'(WIDTH-1);
            mag_b_r  <= mag_b;
            is_rem_r <= div_op_i[1];
            neg_q_r  <= a_neg ^ b_neg;
            neg_r_r  <= a_neg;
            rem_r    <= early ? mag_a : '0;
            quo_r    <= early ? '0 : mag_a;
            if (special) result_o <= special_res;
        end else if (state == ITER) begin
            cnt   <= cnt - 1'b1;
            rem_r <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            quo_r <= {quo_r[WIDTH-2:0], ~trial[WIDTH]};
        end else if (state == FIXUP && !kill_i) begin
            result_o <= fix_res;
        end
    end
endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Multi-cycle sequencer for the core's 32-bit RV32M divide/remainder unit.
- Accepts one DIV/DIVU/REM/REMU request from the EX stage and runs a restoring shift-subtract loop with an iteration counter.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) without iterating.
- Holds the result until EX accepts it. Sits beside the single-cycle ALU and shares its operand buses.

Parameters:
- WIDTH, 32, datapath width. Power of two, at least 8.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  request valid
- div_op_i  in  2  00 DIVU, 01 DIV, 10 REMU, 11 REM
- operand_a_i  in  WIDTH  dividend
- operand_b_i  in  WIDTH  divisor
- ex_ready_i  in  1  consumer accepts result this cycle
- kill_i  in  1  pipeline flush; aborts any operation
- result_o  out  WIDTH  quotient or remainder, registered
- ready_o  out  1  result_o valid
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Clock/reset: one clock (clk). rst_n is asynchronous, active-low.
- Reset: state IDLE; result_o=0, ready_o=0, busy_o=0; counter and internal registers 0. Reset mid-operation discards the operation immediately.
- States:
  - IDLE: request accepted when enable_i=1 and kill_i=0. Operands, op and sign flags are latched. Next state:
    - DONE if operand_b_i=0;
    - DONE if signed op with a=2^(WIDTH-1), b=all-ones;
    - otherwise ITER.
  - ITER: runs exactly WIDTH cycles; counter WIDTH-1 down to 0; last ITER cycle is count=0, then FIXUP.
  - FIXUP: sign correction, result selection, then DONE.
  - DONE: ready_o=1. Transitions to IDLE on ex_ready_i=1.
- Datapath:
  - Magnitudes: signed ops use |a|, |b|; unsigned ops use a, b.
  - Each ITER cycle: {R,Q} shifted left 1 bit. Trial = R - |b| at WIDTH+1 bits. If trial >= 0, R=trial and Q[0]=1.
  - FIXUP, DIV: quotient negated if sign(a) XOR sign(b).
  - FIXUP, REM: remainder negated if sign(a).
- Special-case results (RISC-V):
  - b=0: quotient all-ones, remainder = a.
  - Signed overflow: quotient 2^(WIDTH-1), remainder 0.
- Latency, accept at edge T:
  - Normal op: ITER at T+1..T+WIDTH, FIXUP at T+WIDTH+1, ready_o=1 from T+WIDTH+2 (cycle 34 for WIDTH=32).
  - Special case: ready_o=1 from T+1.
- Handshake:
  - result_o and ready_o are stable while ready_o=1 and ex_ready_i=0.
  - Requests are accepted only in IDLE, so there is one bubble cycle between back-to-back ops. enable_i is ignored while busy_o=1.
- result_o is written only on entry to DONE and holds its value afterwards, including through IDLE.
- kill_i: in any state, next state is IDLE; ready_o=0 and busy_o=0 next cycle; result_o unchanged. kill_i beats enable_i in the same cycle (request not accepted) and beats ex_ready_i in DONE.
- Operand inputs may change after acceptance without effect.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if b!=0 and |a| < |b| as unsigned magnitudes, skip ITER and go straight to FIXUP with Q=0, R=|a|. ready_o=1 from T+2. Sign fixup still applies.
- Undefined: all non-special ops take exactly WIDTH ITER cycles. Latency is fixed at WIDTH+2.

Test Plan:
- DIVU 100/7 -> result_o=14, ready_o first high 34 cycles after accept. REMU 100/7 -> 2.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIV 7/-2 -> 0xFFFFFFFD. REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with ready_o high 1 cycle after accept, busy_o high that cycle.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both 1-cycle latency.
- Backpressure and kill:
  - Hold ex_ready_i=0 for 10 cycles in DONE while toggling enable_i and operands -> result_o/ready_o constant, no new accept.
  - kill_i at ITER cycle 10 -> IDLE next cycle, ready_o never rises; following DIVU 9/3 -> 3.
- Assert rst_n low mid-ITER -> ready_o=0, busy_o=0, result_o=0 immediately.
- With DIV_EARLY_OUT_EN: DIVU 3/10 -> 0 at T+2. REM -3/10 -> 0xFFFFFFFD at T+2.
